// File: rtl/cga_text_fetch_pkg.sv
// CGA text fetch: shared constants, stage bundles, helpers.
// Cell geometry, attribute layout and blink bit indices live here.
package cga_text_fetch_pkg;

  localparam int CELL_W    = 8;
  localparam int GL_W      = 4;
  localparam int GLYPH_MSB = 7;
  localparam int CUR_H     = 2;
  localparam int FCNT_W    = 6;
  localparam int CUR_BIT   = 4;
  localparam int BLINK_BIT = 5;

  localparam int BG_I = 7;
  localparam int BG_R = 6;
  localparam int BG_G = 5;
  localparam int BG_B = 4;
  localparam int FG_I = 3;
  localparam int FG_R = 2;
  localparam int FG_G = 1;
  localparam int FG_B = 0;

  typedef struct packed {
    logic            de;
    logic [2:0]      xs;
    logic [GL_W-1:0] gl;
    logic            hit;
  } s1_t;

  typedef struct packed {
    logic       de;
    logic [2:0] xs;
    logic [7:0] attr;
    logic       hit;
  } s2_t;

  function automatic logic glyph_bit(
    input logic [7:0] row,
    input logic [2:0] xs
  );
    return row[3'(GLYPH_MSB) - xs];
  endfunction

endpackage

// File: rtl/cga_text_fetch_if.sv
// CGA text fetch: VRAM and font ROM read bus.
// Both memories answer combinationally to the registered address.
interface cga_text_fetch_if #(
  parameter int VRAM_AW = 12
);
  logic [VRAM_AW-1:0] vram_addr;
  logic [15:0]        vram_data;
  logic [11:0]        font_addr;
  logic [7:0]         font_data;

  modport master (
    output vram_addr,
    output font_addr,
    input  vram_data,
    input  font_data
  );

  modport slave (
    input  vram_addr,
    input  font_addr,
    output vram_data,
    output font_data
  );
endinterface

// File: rtl/cga_blink_ctr.sv
// CGA text fetch: frame counter for cursor and attribute blink.
// Wraps modulo 64; phases are single counter bits.
module cga_blink_ctr
  import cga_text_fetch_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic frame_i,
  output logic cursor_phase,
  output logic blink_phase
);

  logic [FCNT_W-1:0] cnt;

  // count frame pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt <= '0;
    else if (frame_i) cnt <= cnt + 1'b1;
  end

  assign cursor_phase = cnt[CUR_BIT];
  assign blink_phase  = cnt[BLINK_BIT];

endmodule

// File: rtl/cga_text_fetch.sv
// CGA text fetch: x/y -> VRAM -> font ROM -> pixel, 3-cycle pipe.
// Optional attribute blink under CGA_BLINK_EN.
module cga_text_fetch
  import cga_text_fetch_pkg::*;
#(
  parameter int COLS    = 80,
  parameter int ROWS    = 30,
  parameter int FONT_H  = 16,
  parameter int VRAM_AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              de_i,
  input  logic [9:0]        x_i,
  input  logic [8:0]        y_i,
  input  logic              frame_i,
  cga_text_fetch_if.master  mem,
  input  logic              cursor_en_i,
  input  logic [6:0]        cursor_col_i,
  input  logic [4:0]        cursor_row_i,
  output logic              de_o,
  output logic [7:0]        color_o,
  output logic              on_o
);

  logic [GL_W-1:0]    gl0;
  logic [6:0]         col0;
  logic [8-GL_W:0]    row0;
  logic [VRAM_AW-1:0] addr0;
  logic               cur_ok;
  logic               hit0;

  s1_t s1;
  s2_t s2;

  logic cursor_phase;
  logic blink_phase;

  logic       pix;
  logic       fg;
  logic       on_n;
  logic [7:0] color_n;

  cga_blink_ctr u_blink (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .frame_i      (frame_i),
    .cursor_phase (cursor_phase),
    .blink_phase  (blink_phase)
  );

  assign gl0  = y_i[GL_W-1:0];
  assign col0 = x_i[9:3];
  assign row0 = y_i[8:GL_W];

  assign addr0 = VRAM_AW'(32'(row0) * COLS + 32'(col0));

  assign cur_ok = (32'(cursor_col_i) < COLS)
               && (32'(cursor_row_i) < ROWS);

  assign hit0 = cursor_en_i && cur_ok
             && (32'(col0) == 32'(cursor_col_i))
             && (32'(row0) == 32'(cursor_row_i))
             && (32'(gl0) >= 32'(FONT_H - CUR_H));

  // stage 0: cell address and cursor match
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem.vram_addr <= '0;
      s1            <= '0;
    end else begin
      mem.vram_addr <= addr0;
      s1.de         <= de_i;
      s1.xs         <= x_i[2:0];
      s1.gl         <= gl0;
      s1.hit        <= hit0;
    end
  end

  // stage 1: char -> font address, carry attribute
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem.font_addr <= '0;
      s2            <= '0;
    end else begin
      mem.font_addr <= {mem.vram_data[7:0], s1.gl};
      s2.de         <= s1.de;
      s2.xs         <= s1.xs;
      s2.attr       <= mem.vram_data[15:8];
      s2.hit        <= s1.hit;
    end
  end

  assign pix = glyph_bit(mem.font_data, s2.xs);

  // stage 2: pick glyph bit, apply blink and cursor
  always_comb begin
    fg      = pix;
    on_n    = 1'b0;
    color_n = 8'h00;
    if (s2.de) begin
`ifdef CGA_BLINK_EN
      color_n = {1'b0, s2.attr[BG_R:FG_B]};
      if (s2.attr[BG_I] && blink_phase) fg = 1'b0;
`else
      color_n = s2.attr;
`endif
      on_n = fg | (s2.hit & cursor_phase);
    end
  end

`ifndef CGA_BLINK_EN
  logic unused_blink;
  assign unused_blink = blink_phase;
`endif

  // output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_o    <= 1'b0;
      color_o <= 8'h00;
      on_o    <= 1'b0;
    end else begin
      de_o    <= s2.de;
      color_o <= color_n;
      on_o    <= on_n;
    end
  end

endmodule
